// File: rtl/clk_div_pkg.sv
// Shared types and constants for the fractional clock divider.
package clk_div_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int MIN_DIV   = 2;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] div_int;
        logic [DEF_CNT_W-1:0] frac_num;
        logic [DEF_CNT_W-1:0] frac_den;
    } cfg_t;

    typedef enum logic {
        MODE_INT,
        MODE_FRAC
    } mode_e;

endpackage

// File: rtl/clk_div_frac_if.sv
// Control/status bundle of the fractional clock divider.
interface clk_div_frac_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             cfg_load;
    logic [CNT_W-1:0] div_int;
    logic [CNT_W-1:0] frac_num;
    logic [CNT_W-1:0] frac_den;
    logic             clk_out;
    logic             tick;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (
        output en, cfg_load, div_int, frac_num, frac_den,
        input  clk_out, tick, cfg_ack, cfg_err
    );

    modport slave (
        input  en, cfg_load, div_int, frac_num, frac_den,
        output clk_out, tick, cfg_ack, cfg_err
    );
endinterface

// File: rtl/clk_div_frac_acc.sv
// Dual-modulus period selector: accumulates num per period and picks
// N or N+1 for the period that starts on the wrap edge.
module clk_div_frac_acc
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             step,
    input  logic             clear,
    input  mode_e            mode,
    input  logic [CNT_W-1:0] div_n,
    input  logic [CNT_W-1:0] num,
    input  logic [CNT_W-1:0] den,
    output logic [CNT_W:0]   period
);

    logic [CNT_W:0] acc_q;
    logic [CNT_W:0] acc_sum;
    logic           carry;

    // one extra bit on the sum so acc+num never wraps
    always_comb begin
        acc_sum = acc_q + {1'b0, num};
        carry   = (mode == MODE_FRAC) && (acc_sum >= {1'b0, den});
    end

    // accumulator and next-period length, restarted whenever a config is applied
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            period <= (CNT_W+1)'(DEF_DIV);
        end else if (clear) begin
            acc_q  <= '0;
            period <= {1'b0, div_n};
        end else if (step) begin
            if (mode == MODE_FRAC) begin
                acc_q <= carry ? (acc_sum - {1'b0, den}) : acc_sum;
            end
            period <= {1'b0, div_n} + {{CNT_W{1'b0}}, carry};
        end
    end

endmodule

// File: rtl/clk_div_frac.sv
// Programmable integer/fractional clock divider with clock-enable tick.
// Config changes take effect only at period boundaries (or at once while idle).
// Optional macro CLK_DIV_DUTY50_EN adds a falling-edge flop giving 50% duty
// for odd period lengths.
module clk_div_frac
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = 4
) (
    input  logic           clk_in,
    input  logic           rst,
    clk_div_frac_if.slave  bus
);

    typedef struct packed {
        logic [CNT_W-1:0] div_int;
        logic [CNT_W-1:0] frac_num;
        logic [CNT_W-1:0] frac_den;
    } cfg_w_t;

    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

    cfg_w_t         act_q;
    cfg_w_t         pend_q;
    cfg_w_t         legal;
    cfg_w_t         sel_cfg;
    mode_e          sel_mode;
    logic           legal_err;
    logic           pend_vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0] cnt_inc;
    logic [CNT_W:0] period;
    logic           idle_q;
    logic           wrap;
    logic           restart;
    logic           apply;
    logic           pos_q;
    logic           tick_q;
    logic           ack_q;
    logic           err_q;

    // clamp an illegal pending config into a usable one and flag it
    always_comb begin
        legal     = pend_q;
        legal_err = 1'b0;
        if (pend_q.div_int < CNT_W'(MIN_DIV)) begin
            legal.div_int = CNT_W'(MIN_DIV);
            legal_err     = 1'b1;
        end
        if ((pend_q.frac_den != '0) && (pend_q.frac_num >= pend_q.frac_den)) begin
            legal.frac_num = '0;
            legal.frac_den = '0;
            legal_err      = 1'b1;
        end
    end

    // period boundary detection and config selection for the accumulator
    always_comb begin
        wrap     = bus.en && !idle_q && ({1'b0, cnt_q} == (period - ONE));
        restart  = bus.en && idle_q;
        apply    = pend_vld_q && (wrap || !bus.en);
        cnt_inc  = {1'b0, cnt_q} + ONE;
        sel_cfg  = apply ? legal : act_q;
        sel_mode = (sel_cfg.frac_den != '0) ? MODE_FRAC : MODE_INT;
    end

    clk_div_frac_acc #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_acc (
        .clk_in (clk_in),
        .rst    (rst),
        .step   (wrap && !apply),
        .clear  (apply),
        .mode   (sel_mode),
        .div_n  (sel_cfg.div_int),
        .num    (sel_cfg.frac_num),
        .den    (sel_cfg.frac_den),
        .period (period)
    );

    // period counter and registered outputs; a re-enable starts a fresh period
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_W'(DEF_DIV - 1);
            idle_q <= 1'b0;
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= !bus.en;
            ack_q  <= apply;
            if (apply) begin
                err_q <= legal_err;
            end
            if (bus.en) begin
                cnt_q <= (wrap || restart) ? '0 : cnt_inc[CNT_W-1:0];
            end
            tick_q <= wrap || restart;
            pos_q  <= wrap || restart || (bus.en && (cnt_inc < (period >> 1)));
        end
    end

    // pending/active config registers; a load on the apply edge waits for the next boundary
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            act_q      <= '{div_int: CNT_W'(DEF_DIV), default: '0};
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                pend_q     <= '{div_int: bus.div_int, frac_num: bus.frac_num,
                                frac_den: bus.frac_den};
                pend_vld_q <= 1'b1;
            end else if (apply) begin
                pend_vld_q <= 1'b0;
            end
            if (apply) begin
                act_q <= legal;
            end
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic neg_q;

    // half-cycle delayed copy of the high phase, ORed in for odd periods
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign bus.clk_out = period[0] ? (pos_q | neg_q) : pos_q;
`else
    assign bus.clk_out = pos_q;
`endif

    assign bus.tick    = tick_q;
    assign bus.cfg_ack = ack_q;
    assign bus.cfg_err = err_q;

endmodule

// File: doc/clk_div_frac.md
Name: clk_div_frac

Overview:
Parametrised programmable clock divider; next generation of the team's fixed odd/even divider.
Supports integer divide N≥2 and fractional divide N+num/den (dual-modulus N/N+1 selected by an accumulator).
Configuration is updated glitch-free at period boundaries.
Drives derived slow clocks and clock-enable ticks for downstream logic in the same clk_in domain.

Parameters:
CNT_W, 16, width of divisor, numerator, denominator and period counter
DEF_DIV, 4, integer divisor loaded into the shadow registers at reset (must be ≥2)

Ports:
clk_in  input  1  single clock; all logic on its rising edge, except the optional duty-correction flop
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; low holds the divider idle
cfg_load  input  1  one-cycle strobe; captures div_int/frac_num/frac_den into a pending register
div_int  input  CNT_W  integer divisor N
frac_num  input  CNT_W  fractional numerator
frac_den  input  CNT_W  fractional denominator; 0 selects pure integer mode
clk_out  output  1  divided clock
tick  output  1  one-cycle pulse on the clk_in edge where each output period starts
cfg_ack  output  1  one-cycle pulse when the pending configuration becomes active
cfg_err  output  1  sticky flag: last applied configuration was illegal and was clamped; cleared by the next legal apply

Behaviour:
- Reset values: clk_out=0, tick=0, cfg_ack=0, cfg_err=0, acc=0.
- Reset values: active config = {DEF_DIV, 0, 0}, pending flag=0, cnt=DEF_DIV-1.
- Period length P: N in integer mode. In fractional mode, P is N or N+1, selected per period.
- Half-count H = floor(P/2).
- Each enabled edge:
  - cnt_next = (cnt==P-1) ? 0 : cnt+1; cnt <= cnt_next.
  - clk_out <= (cnt_next < H).
  - tick <= (cnt_next==0).
- Effect: the first enabled edge after reset raises clk_out and tick.
- Even P gives 50% duty. Odd P is high H cycles and low H+1 cycles.
- Fractional accumulator, evaluated at each wrap (cnt==P-1):
  - acc_sum = acc + num.
  - If acc_sum ≥ den: acc <= acc_sum-den and next P=N+1.
  - Otherwise: acc <= acc_sum and next P=N.
  - Width: acc_sum is CNT_W+1 bits, so there is no overflow.
  - Average divide = N+num/den.
- cfg_load:
  - Latches the inputs into the pending register and sets the pending flag.
  - A second cfg_load before apply overwrites the pending values.
- Apply point: at the wrap edge, if pending:
  - Pending becomes active, acc <= 0, and cfg_ack pulses on that edge.
  - The new P governs the period that starts on that edge.
- Simultaneous cfg_load and wrap: the new load is captured and applied at the following wrap. The old pending value, if any, is applied now.
- Legality, checked at apply:
  - N<2 is clamped to 2 and sets cfg_err.
  - den≠0 with num≥den forces integer mode (num treated as 0) and sets cfg_err.
  - A legal apply clears cfg_err.
- en low:
  - cnt, acc and outputs are held; clk_out and tick are driven 0.
  - Pending configuration applies immediately on the first edge of en=0.
  - On re-enable, cnt restarts so the next edge gives cnt_next=0 (fresh period, tick=1).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The pending configuration is discarded.

Optional Feature:
- Macro CLK_DIV_DUTY50_EN.
- Defined:
  - A falling-edge flop samples the registered high phase (pos_q).
  - For odd P, clk_out = pos_q | neg_q, i.e. high for H+0.5 cycles, giving 50% duty.
  - Even P is unaffected.
  - The falling-edge flop resets to 0 asynchronously.
- Undefined: no falling-edge logic; odd P uses the H / H+1 duty defined above.

Decomposition:
- Shared package clk_div_pkg:
  - CNT_W default.
  - MIN_DIV=2 constant.
  - cfg struct typedef {div_int, frac_num, frac_den}.
  - mode enum {MODE_INT, MODE_FRAC}.
- One sub-module, clk_div_frac_acc:
  - Contains the accumulator, compare/subtract, and N/N+1 period select.
  - Inputs: wrap strobe, active config, clear.
  - Outputs: P for the next period.

Test Plan:
- Reset, then release with en=1 and DEF_DIV=4 → clk_out pattern 1100 repeating; tick every 4 clk_in; cfg_err=0.
- Load N=5 integer mid-period → current period completes; cfg_ack at the wrap; then 11000 repeating. With CLK_DIV_DUTY50_EN, high lasts 2.5 clk_in.
- Load N=3, num=1, den=2 → period lengths 3,4,3,4…; 100 tick periods span exactly 350 clk_in.
- Load N=1, num=3, den=2 → N=2, integer mode, cfg_err=1. A following legal load N=6 clears cfg_err at its apply.
- en low for 10 cycles mid-period → clk_out=0 and tick=0 throughout; first edge after en rises gives tick=1 and clk_out=1.
- Assert rst mid-fractional run → outputs 0 immediately; after release, behaviour is identical to the first scenario (DEF_DIV).
